// File: rtl/debounce_pkg.sv
// debounce_pkg -- shared types and defaults for the debouncer.
//   state_t                : 2-bit qualification state encoding
//   DEFAULT_STABLE_CYCLES  : consecutive samples needed to accept a new level
//   DEFAULT_SYNC_STAGES    : synchronizer depth
//   is_qual()              : true while a candidate transition is being qualified
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    QUAL_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    QUAL_LOW    = 2'b11
  } state_t;

  localparam int DEFAULT_STABLE_CYCLES = 16;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  function automatic logic is_qual(input state_t st);
    return (st == QUAL_HIGH) || (st == QUAL_LOW);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain -- multi-flop synchronizer for a single asynchronous bit.
//   clock : sampling clock (rising edge)
//   reset : synchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// debouncer -- synchronizes a raw switch level and accepts a new level only
// after STABLE_CYCLES consecutive matching samples.
//   clock    : sole clock, rising edge
//   reset    : synchronous active-low reset
//   dataIn   : raw asynchronous level
//   dataOut  : registered debounced level
//   changing : registered, high while a candidate transition is qualified
// Build option: DEBOUNCER_BYPASS_EN removes the qualification logic, so
// dataOut is the synchronized sample and changing is tied low.
//
// state       | meaning
// ------------+---------------------------------------------
// STABLE_LOW  | dataOut=0, sample agrees
// QUAL_HIGH   | dataOut=0, counting consecutive high samples
// STABLE_HIGH | dataOut=1, sample agrees
// QUAL_LOW    | dataOut=1, counting consecutive low samples
module debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic dataIn,
  output logic dataOut,
  output logic changing
);

  logic s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (dataIn),
    .q     (s)
  );

`ifdef DEBOUNCER_BYPASS_EN

  assign dataOut  = s;
  assign changing = 1'b0;

`else

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // Count value on the edge before acceptance; the accepting edge clears.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_out_q, data_out_d;
  logic             changing_q, changing_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= STABLE_LOW;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      changing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      changing_q <= changing_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LOW: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            state_d = QUAL_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else begin
            state_d = QUAL_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QUAL_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state change; the level only moves on entry to a stable state.
  always_comb begin
    data_out_d = (state_d == STABLE_HIGH) || (state_d == QUAL_LOW);
    changing_d = is_qual(state_d);
  end

  assign dataOut  = data_out_q;
  assign changing = changing_q;

`endif

endmodule

// File: tb/tb_debouncer.sv
module tb_debouncer;

  logic clk;
  logic reset;
  logic data_in;
  logic dout4, chg4;
  logic dout1, chg1;

  int checks = 0;
  int errors = 0;

  debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clock    (clk),
    .reset    (reset),
    .dataIn   (data_in),
    .dataOut  (dout4),
    .changing (chg4)
  );

  debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2)) dut1 (
    .clock    (clk),
    .reset    (reset),
    .dataIn   (data_in),
    .dataOut  (dout1),
    .changing (chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    data_in = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_do, exp_ch, exp_do1;
    reset   = 1'b0;
    data_in = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (dout4 !== 1'b0 || chg4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: dataOut=%b changing=%b, required 0 0", c, dout4, chg4);
      end
      checks++;
      if (dout1 !== 1'b0 || chg1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_sc1 cyc %0d: dataOut=%b changing=%b, required 0 0", c, dout1, chg1);
      end
    end
    reset = 1'b1;
`ifdef DEBOUNCER_BYPASS_EN
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_do = (e >= 2);
      checks++;
      if (dout4 !== exp_do || chg4 !== 1'b0) begin
        errors++;
        $display("FAIL bypass_release edge %0d: dataOut=%b changing=%b, required %b 0", e, dout4, chg4, exp_do);
      end
    end
`else
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_do  = (e >= 6);
      exp_ch  = (e >= 3) && (e <= 5);
      exp_do1 = (e >= 3);
      checks++;
      if (dout4 !== exp_do || chg4 !== exp_ch) begin
        errors++;
        $display("FAIL reset_release edge %0d: dataOut=%b changing=%b, required %b %b", e, dout4, chg4, exp_do, exp_ch);
      end
      checks++;
      if (dout1 !== exp_do1 || chg1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_sc1 edge %0d: dataOut=%b changing=%b, required %b 0", e, dout1, chg1, exp_do1);
      end
    end
`endif
  endtask

  task automatic test_glitch();
    logic exp_ch;
    do_reset();
    data_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) data_in = 1'b0;
      exp_ch = (e >= 3) && (e <= 5);
      checks++;
      if (dout4 !== 1'b0 || chg4 !== exp_ch) begin
        errors++;
        $display("FAIL glitch edge %0d: dataOut=%b changing=%b, required 0 %b", e, dout4, chg4, exp_ch);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_do, exp_ch;
    do_reset();
    data_in = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 5) data_in = 1'b0;
      exp_do = (e >= 6) && (e <= 10);
      exp_ch = ((e >= 3) && (e <= 5)) || ((e >= 8) && (e <= 10));
      checks++;
      if (dout4 !== exp_do || chg4 !== exp_ch) begin
        errors++;
        $display("FAIL clean_press edge %0d: dataOut=%b changing=%b, required %b %b", e, dout4, chg4, exp_do, exp_ch);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_in = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    checks++;
    if (chg4 !== 1'b1 || dout4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_qual_setup: dataOut=%b changing=%b, required 0 1", dout4, chg4);
    end
    reset   = 1'b0;
    data_in = 1'b0;
    tick();
    checks++;
    if (dout4 !== 1'b0 || chg4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_qual_reset: dataOut=%b changing=%b, required 0 0", dout4, chg4);
    end
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (dout4 !== 1'b0 || chg4 !== 1'b0) begin
        errors++;
        $display("FAIL mid_qual_after edge %0d: dataOut=%b changing=%b, required 0 0", e, dout4, chg4);
      end
    end
  endtask

  task automatic test_stable_one();
    logic exp_do1;
    do_reset();
    data_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) data_in = 1'b0;
      exp_do1 = (e >= 3) && (e <= 8);
      checks++;
      if (dout1 !== exp_do1 || chg1 !== 1'b0) begin
        errors++;
        $display("FAIL stable_one edge %0d: dataOut=%b changing=%b, required %b 0", e, dout1, chg1, exp_do1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_do;
    // Two clean presses separated by exactly the qualification window.
    do_reset();
    data_in = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      tick();
      if (e == 5)  data_in = 1'b0;
      if (e == 10) data_in = 1'b1;
      if (e == 15) data_in = 1'b0;
      exp_do = ((e >= 6) && (e <= 10)) || ((e >= 16) && (e <= 20));
      checks++;
      if (dout4 !== exp_do) begin
        errors++;
        $display("FAIL back_to_back edge %0d: dataOut=%b, required %b", e, dout4, exp_do);
      end
    end
  endtask

  task automatic test_bypass();
    logic exp_do;
    do_reset();
    data_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 2) data_in = 1'b0;
      exp_do = (e >= 2) && (e <= 3);
      checks++;
      if (dout4 !== exp_do || chg4 !== 1'b0) begin
        errors++;
        $display("FAIL bypass_pulse edge %0d: dataOut=%b changing=%b, required %b 0", e, dout4, chg4, exp_do);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    test_reset();
`ifdef DEBOUNCER_BYPASS_EN
    test_bypass();
`else
    test_glitch();
    test_clean_press();
    test_reset_mid();
    test_stable_one();
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive synchronized samples required to accept a new level; legal range 1..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth; legal range 2..4.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock.
REQ-005 SHALL have port dataIn  input  1  raw asynchronous level from a switch or button.
REQ-006 SHALL have port dataOut  output  1  registered debounced level; drives the dataIn of the downstream Pulser stage.
REQ-007 SHALL have port changing  output  1  registered; 1 while a candidate transition is being qualified.

Function
REQ-008 SHALL pass dataIn through SYNC_STAGES flops; the last stage is the synchronized sample s.
REQ-009 SHALL implement four states: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW.
REQ-010 SHALL hold a counter of width clog2(STABLE_CYCLES+1) that counts consecutive samples where s differs from dataOut.
REQ-011 STABLE_LOW with s=1: counter=1 and go to QUAL_HIGH; if STABLE_CYCLES=1, go directly to STABLE_HIGH with dataOut=1 on the same edge.
REQ-012 QUAL_HIGH with s=1: increment the counter; on the edge where it reaches STABLE_CYCLES, set dataOut=1, clear the counter and go to STABLE_HIGH.
REQ-013 QUAL_HIGH with s=0: clear the counter and return to STABLE_LOW; dataOut stays unchanged (glitch rejected).
REQ-014 STABLE_HIGH and QUAL_LOW SHALL mirror REQ-011 to REQ-013 with the polarities inverted.
REQ-015 changing SHALL be 1 exactly when the state is QUAL_HIGH or QUAL_LOW.
REQ-016 For a clean step on dataIn, dataOut SHALL change on the (SYNC_STAGES+STABLE_CYCLES)th rising edge after the first edge that samples the new level.
REQ-017 The counter SHALL never exceed STABLE_CYCLES and SHALL never wrap.

Reset
REQ-018 While reset=0 at a clock edge: all synchronizer flops=0, state=STABLE_LOW, counter=0, dataOut=0, changing=0.
REQ-019 Reset asserted mid-qualification SHALL abandon the qualification, with the REQ-018 values visible after that same edge.
REQ-020 After reset release with dataIn held at 1, dataOut SHALL rise per REQ-016, counted from the first edge with reset=1.

Configuration
REQ-021 Macro DEBOUNCER_BYPASS_EN defined: no state machine or counter; dataOut = s (latency SYNC_STAGES edges); changing tied to 0; reset values as in REQ-018.
REQ-022 Macro DEBOUNCER_BYPASS_EN undefined: full qualification behaviour per REQ-009 to REQ-017.

Structure
REQ-023 Package debounce_pkg SHALL hold the state enum typedef (2 bits), DEFAULT_STABLE_CYCLES=16 and DEFAULT_SYNC_STAGES=2.
REQ-024 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clock, reset, d, q), instantiated once.

Verification (10 ns clock, STABLE_CYCLES=4, SYNC_STAGES=2 unless stated)
REQ-025 Reset: reset=0 for 3 cycles with dataIn=1 -> dataOut=0 and changing=0 throughout; after release, changing=1 from edge 3 and dataOut=1 at edge 6.
REQ-026 Glitch: dataIn=1 for 30 ns, then 0 -> dataOut stays 0; changing=1 for exactly 3 cycles, then 0.
REQ-027 Clean press: dataIn=1 for 50 ns, then 0 -> dataOut rises 6 edges after the rise and falls 6 edges after the fall; each step is 1 cycle of latency apart.
REQ-028 Reset mid-qualification: reset=0 while changing=1 -> next edge shows dataOut=0, changing=0; no spurious dataOut=1 after release with dataIn=0.
REQ-029 DEBOUNCER_BYPASS_EN defined: a 20 ns pulse on dataIn -> identical 20 ns pulse on dataOut delayed 2 edges; changing=0 throughout.
REQ-030 STABLE_CYCLES=1: step on dataIn -> dataOut follows at edge 3; changing never asserts.
